// File: rtl/ramcollection_pkg.sv
// Shared types for the ramcollection RAM blocks.
package ramcollection_pkg;

    typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;
    typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: LATENCY register stages, each stage's data loaded only when its input valid is set.
module ram_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [LATENCY:1]            vld_q;
    logic [LATENCY:1][WIDTH-1:0] dat_q;
    logic [LATENCY:0]            vld_pipe;
    logic [LATENCY:0][WIDTH-1:0] dat_pipe;

    assign vld_pipe = {vld_q, in_valid_i};
    assign dat_pipe = {dat_q, in_data_i};

    // Gating data on valid keeps the output word stable between results.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_pipe[LATENCY-1:0];
            for (int s = 1; s <= LATENCY; s++) begin
                if (vld_pipe[s-1]) dat_q[s] <= dat_pipe[s-1];
            end
        end
    end

    assign valid_o = vld_pipe[LATENCY];
    assign data_o  = dat_pipe[LATENCY];

endmodule

// File: rtl/ram_sdp1c_pipe.sv
// Single-clock simple dual-port RAM: byte-enabled write port A, pipelined read port B,
// selectable read-during-write and optional zero-fill after reset.
module ram_sdp1c_pipe
    import ramcollection_pkg::*;
#(
    parameter int        WORD_WIDTH     = 32,
    parameter int        BYTE_WIDTH     = 8,
    parameter int        WORD_COUNT     = 256,
    parameter int        READ_LATENCY   = 1,
    parameter rdw_mode_e RDW_MODE       = RDW_OLD,
    parameter bit        CLEAR_ON_RESET = 1'b1,
    parameter string     INIT_FILE      = "",
    parameter bit        INIT_FILE_BIN  = 1'b0,
    localparam int       ADDR_WIDTH     = $clog2(WORD_COUNT),
    localparam int       BE_WIDTH       = WORD_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  we_a_i,
    input  logic [BE_WIDTH-1:0]   be_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [WORD_WIDTH-1:0] data_a_i,
    input  logic                  re_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    output logic [WORD_WIDTH-1:0] data_b_o,
    output logic                  valid_b_o,
    output logic                  busy_o
);

    if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_err_width
        $error("WORD_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_err_lat
        $error("READ_LATENCY must be 1..3");
    end
    if (WORD_COUNT < 2) begin : g_err_count
        $error("WORD_COUNT must be >= 2");
    end
    if (CLEAR_ON_RESET && INIT_FILE != "") begin : g_err_init
        $error("INIT_FILE cannot be combined with CLEAR_ON_RESET");
    end

    localparam logic [ADDR_WIDTH:0]   WC_EXT    = (ADDR_WIDTH+1)'(WORD_COUNT);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);

    logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

    clr_state_e            clr_state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  a_in_range, b_in_range, wr_ok, rd_acc;
    logic [WORD_WIDTH-1:0] rd_word;

    assign busy_o     = (clr_state == CLR_RUN);
    assign a_in_range = {1'b0, addr_a_i} < WC_EXT;
    assign b_in_range = {1'b0, addr_b_i} < WC_EXT;
    assign wr_ok      = !busy_o && we_a_i && a_in_range;
    assign rd_acc     = !busy_o && re_b_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            clr_state <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
            clr_cnt   <= '0;
        end else if (clr_state == CLR_RUN) begin
            if (clr_cnt == LAST_ADDR) begin
                clr_state <= CLR_IDLE;
                clr_cnt   <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Array has no reset; clearing is done one word per cycle by the FSM.
    always_ff @(posedge clk_i) begin
        if (busy_o) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (be_a_i[k]) mem[addr_a_i][k*BYTE_WIDTH +: BYTE_WIDTH] <= data_a_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Array read happens before the write edge, so the plain read already yields old data.
    always_comb begin
        rd_word = '0;
        if (b_in_range) begin
            rd_word = mem[addr_b_i];
            if (RDW_MODE == RDW_NEW && wr_ok && addr_a_i == addr_b_i) begin
                for (int k = 0; k < BE_WIDTH; k++) begin
                    if (be_a_i[k]) rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = data_a_i[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    ram_rd_pipe #(
        .WIDTH  (WORD_WIDTH),
        .LATENCY(READ_LATENCY)
    ) u_rd_pipe (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .in_valid_i(rd_acc),
        .in_data_i (rd_word),
        .valid_o   (valid_b_o),
        .data_o    (data_b_o)
    );

    a_ctl_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !$isunknown(we_a_i) && !$isunknown(re_b_i));
    a_wr_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
        we_a_i |-> !$isunknown({addr_a_i, be_a_i}));
    a_rd_known: assert property (@(posedge clk_i) disable iff (!rstn_i)
        re_b_i |-> !$isunknown(addr_b_i));

endmodule

// File: tb/tb_ram_sdp1c_pipe.sv
// Bench for ram_sdp1c_pipe: four configurations driven in parallel, checked against an array model.
module tb_ram_sdp1c_pipe;
    import ramcollection_pkg::*;

    localparam int N = 4;
    localparam int P_WC  [N] = '{256, 256, 256, 200};
    localparam int P_LAT [N] = '{1, 2, 3, 2};
    localparam bit P_NEW [N] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, we, re;
    logic [3:0]  be;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] data_a;
    logic [31:0] data_b  [N];
    logic        valid_b [N];
    logic        busy    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        ram_sdp1c_pipe #(
            .WORD_WIDTH    (32),
            .BYTE_WIDTH    (8),
            .WORD_COUNT    (P_WC[g]),
            .READ_LATENCY  (P_LAT[g]),
            .RDW_MODE      (P_NEW[g] ? RDW_NEW : RDW_OLD),
            .CLEAR_ON_RESET(1'b1),
            .INIT_FILE     (""),
            .INIT_FILE_BIN (1'b0)
        ) u_dut (
            .clk_i    (clk),
            .rstn_i   (rstn),
            .we_a_i   (we),
            .be_a_i   (be),
            .addr_a_i (addr_a),
            .data_a_i (data_a),
            .re_b_i   (re),
            .addr_b_i (addr_b),
            .data_b_o (data_b[g]),
            .valid_b_o(valid_b[g]),
            .busy_o   (busy[g])
        );
    end

    int          cyc, n_cmp, n_err;
    logic [31:0] mmem     [N][256];
    int          clr_left [N];
    int          due      [N][8];
    logic [31:0] edat     [N][8];
    logic [31:0] last     [N];

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %h want %h", name, i, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            clr_left[i] = P_WC[i];
            last[i]     = '0;
            for (int s = 0; s < 8; s++) due[i][s] = -1;
        end
    endtask

    // Applies one rising edge to the model: clear, read capture with RDW rule, then write.
    task automatic model_edge();
        logic [31:0] d;
        int t;
        cyc++;
        if (!rstn) return;
        for (int i = 0; i < N; i++) begin
            if (clr_left[i] > 0) begin
                mmem[i][P_WC[i] - clr_left[i]] = '0;
                clr_left[i]--;
            end else begin
                if (re) begin
                    d = (int'(addr_b) < P_WC[i]) ? mmem[i][addr_b] : 32'h0;
                    if (P_NEW[i] && we && addr_a == addr_b && int'(addr_b) < P_WC[i])
                        for (int k = 0; k < 4; k++) if (be[k]) d[k*8 +: 8] = data_a[k*8 +: 8];
                    t = cyc + P_LAT[i] - 1;
                    due[i][t % 8]  = t;
                    edat[i][t % 8] = d;
                end
                if (we && int'(addr_a) < P_WC[i])
                    for (int k = 0; k < 4; k++) if (be[k]) mmem[i][addr_a][k*8 +: 8] = data_a[k*8 +: 8];
            end
        end
    endtask

    task automatic compare_all();
        logic ev;
        for (int i = 0; i < N; i++) begin
            ev = (due[i][cyc % 8] == cyc);
            if (ev) last[i] = edat[i][cyc % 8];
            check("valid", i, 32'(valid_b[i]), 32'(ev));
            check("data", i, data_b[i], last[i]);
            check("busy", i, 32'(busy[i]), 32'(clr_left[i] > 0));
        end
    endtask

    task automatic cyc_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; addr_a = a; data_a = d; be = b; re = 1'b0;
        cyc_step();
        we = 1'b0;
    endtask

    // Issues one read (any write already set up rides along) and pins each instance's result at its latency.
    task automatic read_lit(input logic [7:0] a, input logic [N-1:0][31:0] lit);
        re = 1'b1; addr_b = a;
        for (int t = 1; t <= 3; t++) begin
            cyc_step();
            idle();
            for (int i = 0; i < N; i++) begin
                if (P_LAT[i] == t) begin
                    check("lit_valid", i, 32'(valid_b[i]), 32'd1);
                    check("lit_data", i, data_b[i], lit[i]);
                end else if (P_LAT[i] > t) begin
                    check("lit_early", i, 32'(valid_b[i]), 32'd0);
                end
            end
        end
    endtask

    task automatic poke();
        we = 1'b1; re = 1'b1; addr_a = 8'd7; addr_b = 8'd7; data_a = 32'hFFFF_FFFF; be = 4'hF;
    endtask

    task automatic clear_wait(input bit pk);
        int cnt [N];
        bit any;
        for (int i = 0; i < N; i++) cnt[i] = busy[i] ? 1 : 0;
        for (int n = 0; n < 300; n++) begin
            if (pk && n < 200) poke(); else idle();
            cyc_step();
            any = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (busy[i]) cnt[i]++;
                any |= busy[i];
            end
            if (!any) break;
        end
        idle();
        for (int i = 0; i < N; i++) check("busy_len", i, 32'(cnt[i]), 32'(P_WC[i]));
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        rstn = 1'b0; we = 1'b0; re = 1'b0; be = '0; addr_a = '0; addr_b = '0; data_a = '0;
        model_reset();
        repeat (3) cyc_step();
        for (int i = 0; i < N; i++) begin
            check("rst_busy", i, 32'(busy[i]), 32'd1);
            check("rst_valid", i, 32'(valid_b[i]), 32'd0);
            check("rst_data", i, data_b[i], 32'h0);
        end

        rstn = 1'b1;
        clear_wait(1'b0);
        for (int a = 0; a < 256; a++) begin
            re = 1'b1; addr_b = 8'(a);
            cyc_step();
        end
        idle();
        repeat (4) cyc_step();
        read_lit(8'd255, '0);

        wr(8'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(8'd5, 32'h0000_00AA, 4'b0001);
        read_lit(8'd5, {4{32'hDEAD_BEAA}});

        wr(8'd9, 32'h1111_1111, 4'b1111);
        we = 1'b1; addr_a = 8'd9; data_a = 32'h2222_2222; be = 4'b0011;
        read_lit(8'd9, {32'h1111_2222, 32'h1111_1111, 32'h1111_2222, 32'h1111_1111});
        read_lit(8'd9, {4{32'h1111_2222}});

        for (int k = 0; k < 16; k++) wr(8'(k), 32'hA000_0000 + 32'(k), 4'hF);
        for (int j = 0; j < 19; j++) begin
            re = (j < 16); addr_b = 8'(j);
            cyc_step();
            if (j >= 2 && j < 18) begin
                check("burst_valid", 2, 32'(valid_b[2]), 32'd1);
                check("burst_data", 2, data_b[2], 32'hA000_0000 + 32'(j - 2));
            end else begin
                check("burst_gap", 2, 32'(valid_b[2]), 32'd0);
            end
        end
        idle();

        rstn = 1'b0; model_reset();
        repeat (2) cyc_step();
        rstn = 1'b1;
        for (int n = 0; n < 100; n++) begin
            poke();
            cyc_step();
        end
        idle();
        check("busy_mid", 0, 32'(busy[0]), 32'd1);
        rstn = 1'b0; model_reset();
        cyc_step();
        rstn = 1'b1;
        clear_wait(1'b1);
        read_lit(8'd7, '0);
        read_lit(8'd5, '0);

        wr(8'd50, 32'h1234_5678, 4'hF);
        wr(8'd250, 32'h5555_5555, 4'hF);
        read_lit(8'd50, {4{32'h1234_5678}});
        read_lit(8'd250, {32'h0, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555});

        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom); re = 1'($urandom); be = 4'($urandom); data_a = $urandom;
            addr_a = 1'($urandom) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(190, 255));
            addr_b = 1'($urandom) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(190, 255));
            cyc_step();
        end
        idle();
        repeat (4) cyc_step();

        re = 1'b1; addr_b = 8'd9;
        cyc_step();
        idle();
        rstn = 1'b0; model_reset();
        repeat (3) begin
            cyc_step();
            for (int i = 0; i < N; i++) check("drop_valid", i, 32'(valid_b[i]), 32'd0);
        end
        rstn = 1'b1;
        clear_wait(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
